// File: rtl/upl_regbank_pkg.sv
// Shared constants for the UPL register bank: opcodes, header word indices,
// result error code and controller state encoding.
package upl_regbank_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] RES_ERR  = 2'b11;

    localparam int HDR_SRC_IP = 0;
    localparam int HDR_DST_IP = 1;
    localparam int HDR_PORTS  = 2;
    localparam int HDR_LEN    = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_RX      = 3'd2,
        ST_TX_REQ  = 3'd3,
        ST_TX_WAIT = 3'd4,
        ST_TX      = 3'd5
    } state_t;

    // Exchange the {src port, dst port} halves for the reply header
    function automatic logic [31:0] swap_ports(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

endpackage

// File: rtl/upl_reply_fifo.sv
// Result-word FIFO: filled while commands execute, drained while the reply is sent.
module upl_reply_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [0:DEPTH-1];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && (r_count != {CW{1'b0}});

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/upl_regbank.sv
// UDP-controlled register bank: executes command words from a UPL receive
// packet against N_REG registers and answers with one result word per command.
module upl_regbank
    import upl_regbank_pkg::*;
#(
    parameter int N_REG     = 4,
    parameter int REG_W     = 8,
    parameter int MAX_CMDS  = 16,
    parameter int HDR_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            UPL_input_data,
    input  logic                   UPL_input_en,
    input  logic                   UPL_input_req,
    output logic                   UPL_input_ack,
    output logic [31:0]            UPL_output_data,
    output logic                   UPL_output_en,
    output logic                   UPL_output_req,
    input  logic                   UPL_output_ack,
    output logic [N_REG*REG_W-1:0] reg_out
);
    localparam int CW = $clog2(MAX_CMDS) + 1;
    localparam int TW = CW + 2;
    localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_hdr [0:3];
    logic [2:0]        r_hdr_cnt;
    logic              r_seen_en;
    logic [CW-1:0]     r_ncmd;
    logic [TW-1:0]     r_tx_idx;
    logic [REG_W-1:0]  r_regs [0:N_REG-1];

    logic [1:0]        w_op;
    logic [5:0]        w_addr;
    logic [AW-1:0]     w_idx;
    logic              w_addr_ok;
    logic              w_exec;
    logic              w_wr_en;
    logic [31:0]       w_result;
    logic [31:0]       w_head;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_full;
    logic              w_pop;
    logic [TW-1:0]     w_tx_total;
    logic              w_in_ack_nxt;
    logic              w_out_req_nxt;
    logic              w_out_en_nxt;
    logic [31:0]       w_out_data_nxt;

    assign w_op       = UPL_input_data[31:30];
    assign w_addr     = UPL_input_data[29:24];
    assign w_idx      = w_addr[AW-1:0];
    assign w_addr_ok  = ({1'b0, w_addr} < 7'(N_REG));
    assign w_exec     = (r_state == ST_RX) && UPL_input_en &&
                        (r_hdr_cnt == 3'(HDR_WORDS)) && !w_fifo_full;
    assign w_tx_total = TW'(HDR_WORDS) + TW'(r_ncmd);

    // Result word for the command on the input bus and its register write enable
    always_comb begin
        w_result = {RES_ERR, w_addr, 24'h0};
        w_wr_en  = 1'b0;
        if (w_addr_ok) begin
            case (w_op)
                OP_NOP:   w_result = UPL_input_data;
                OP_WRITE: begin
                    w_result = UPL_input_data;
                    w_wr_en  = w_exec;
                end
                OP_READ:  w_result = {UPL_input_data[31:24], 24'(r_regs[w_idx])};
                default:  w_result = {RES_ERR, w_addr, 24'h0};
            endcase
        end else begin
            w_result = {RES_ERR, w_addr, 24'h0};
        end
    end

    upl_reply_fifo #(.DEPTH(MAX_CMDS), .W(32), .CW(CW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_exec),
        .i_data  (w_result),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; an input request is only accepted from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (UPL_input_req) w_state_nxt = ST_ACK;
                        else               w_state_nxt = ST_IDLE;
            ST_ACK:     w_state_nxt = ST_RX;
            ST_RX:      if (!UPL_input_en && r_seen_en)
                            w_state_nxt = (w_fifo_count != {CW{1'b0}}) ? ST_TX_REQ : ST_IDLE;
                        else
                            w_state_nxt = ST_RX;
            ST_TX_REQ,
            ST_TX_WAIT: if (UPL_output_ack) w_state_nxt = ST_TX;
                        else                w_state_nxt = ST_TX_WAIT;
            ST_TX:      if (r_tx_idx == w_tx_total) w_state_nxt = ST_IDLE;
                        else                        w_state_nxt = ST_TX;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: values the output registers take on the next edge
    always_comb begin
        w_in_ack_nxt   = (r_state == ST_IDLE) && UPL_input_req;
        w_out_req_nxt  = (w_state_nxt == ST_TX_REQ) || (w_state_nxt == ST_TX_WAIT);
        w_out_en_nxt   = (r_state == ST_TX) && (r_tx_idx != w_tx_total);
        w_pop          = w_out_en_nxt && (r_tx_idx >= TW'(HDR_WORDS));
        w_out_data_nxt = 32'h0;
        if (w_out_en_nxt) begin
            case (r_tx_idx)
                TW'(HDR_SRC_IP): w_out_data_nxt = r_hdr[HDR_DST_IP];
                TW'(HDR_DST_IP): w_out_data_nxt = r_hdr[HDR_SRC_IP];
                TW'(HDR_PORTS):  w_out_data_nxt = swap_ports(r_hdr[HDR_PORTS]);
                TW'(HDR_LEN):    w_out_data_nxt = {14'(r_ncmd), 2'b00, 16'h0};
                default:         w_out_data_nxt = w_head;
            endcase
        end else begin
            w_out_data_nxt = 32'h0;
        end
    end

    // Registered UPL handshake and reply outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            UPL_input_ack   <= 1'b0;
            UPL_output_req  <= 1'b0;
            UPL_output_en   <= 1'b0;
            UPL_output_data <= 32'h0;
        end else begin
            UPL_input_ack   <= w_in_ack_nxt;
            UPL_output_req  <= w_out_req_nxt;
            UPL_output_en   <= w_out_en_nxt;
            UPL_output_data <= w_out_data_nxt;
        end
    end

    // Receive bookkeeping: header capture, end-of-packet tracking, reply length, TX index
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_hdr[i] <= 32'h0;
            r_hdr_cnt <= 3'd0;
            r_seen_en <= 1'b0;
            r_ncmd    <= {CW{1'b0}};
            r_tx_idx  <= {TW{1'b0}};
        end else begin
            if (r_state == ST_IDLE) begin
                r_hdr_cnt <= 3'd0;
                r_seen_en <= 1'b0;
            end
            if ((r_state == ST_RX) && UPL_input_en) begin
                r_seen_en <= 1'b1;
                if (r_hdr_cnt != 3'(HDR_WORDS)) begin
                    r_hdr[r_hdr_cnt[1:0]] <= UPL_input_data;
                    r_hdr_cnt             <= r_hdr_cnt + 3'd1;
                end
            end
            if ((r_state == ST_RX) && (w_state_nxt != ST_RX)) r_ncmd <= w_fifo_count;
            if (r_state != ST_TX)  r_tx_idx <= {TW{1'b0}};
            else if (w_out_en_nxt) r_tx_idx <= r_tx_idx + TW'(1);
        end
    end

    // Output register file
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REG; i++) r_regs[i] <= {REG_W{1'b0}};
        end else if (w_wr_en) begin
            r_regs[w_idx] <= UPL_input_data[REG_W-1:0];
        end
    end

    for (genvar g = 0; g < N_REG; g++) begin : g_reg_out
        assign reg_out[g*REG_W +: REG_W] = r_regs[g];
    end

endmodule

// File: tb/tb_upl_regbank.sv
// Randomised scoreboard bench for upl_regbank: a driver builds packets and a
// reference model predicts replies and register contents; a monitor checks replies.
module tb_upl_regbank;
    localparam int N_REG     = 4;
    localparam int REG_W     = 8;
    localparam int MAX_CMDS  = 16;
    localparam int HDR_WORDS = 4;
    localparam int RW        = N_REG * REG_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   UPL_input_data = 32'h0;
    logic          UPL_input_en = 1'b0;
    logic          UPL_input_req = 1'b0;
    logic          UPL_input_ack;
    logic [31:0]   UPL_output_data;
    logic          UPL_output_en;
    logic          UPL_output_req;
    logic          UPL_output_ack = 1'b0;
    logic [RW-1:0] reg_out;

    int            n_vec = 0;
    int            n_err = 0;
    int            ack_delay = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   cmd_q[$];
    logic [REG_W-1:0] m_regs [N_REG];

    upl_regbank #(.N_REG(N_REG), .REG_W(REG_W), .MAX_CMDS(MAX_CMDS), .HDR_WORDS(HDR_WORDS)) dut (
        .clk             (clk),
        .reset           (reset),
        .UPL_input_data  (UPL_input_data),
        .UPL_input_en    (UPL_input_en),
        .UPL_input_req   (UPL_input_req),
        .UPL_input_ack   (UPL_input_ack),
        .UPL_output_data (UPL_output_data),
        .UPL_output_en   (UPL_output_en),
        .UPL_output_req  (UPL_output_req),
        .UPL_output_ack  (UPL_output_ack),
        .reg_out         (reg_out)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] model_regout();
        logic [RW-1:0] r;
        for (int i = 0; i < N_REG; i++) r[i*REG_W +: REG_W] = m_regs[i];
        return r;
    endfunction

    // Reference behaviour of one command: returns its result word, updates the model registers
    task automatic model_cmd(input logic [31:0] c, output logic [31:0] res);
        int op;
        int a;
        op = int'(c[31:30]);
        a  = int'(c[29:24]);
        if (a >= N_REG || op == 3) begin
            res = {2'b11, c[29:24], 24'h0};
        end else if (op == 1) begin
            m_regs[a] = c[REG_W-1:0];
            res = c;
        end else if (op == 2) begin
            res = {c[31:24], 24'(m_regs[a])};
        end else begin
            res = c;
        end
    endtask

    // Send one packet made of the header and cmd_q, predicting reg_out and the reply
    task automatic send_packet(input logic [31:0] sip, input logic [31:0] dip, input logic [31:0] ports);
        logic [31:0] pk[$];
        logic [31:0] res[$];
        logic [31:0] r;
        bit          got;
        pk = {sip, dip, ports, {16'(4 * cmd_q.size()), 16'h0}};
        foreach (cmd_q[i]) pk.push_back(cmd_q[i]);
        cmd_q.delete();
        @(negedge clk);
        UPL_input_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            if (UPL_input_ack) got = 1'b1;
        end
        UPL_input_req = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL input_ack_timeout: got no ack expected ack within 2000 cycles");
            return;
        end
        for (int i = 0; i < pk.size(); i++) begin
            @(negedge clk);
            if (i > HDR_WORDS) check("reg_out_after_cmd", reg_out, model_regout());
            UPL_input_data = pk[i];
            UPL_input_en   = 1'b1;
            if (i >= HDR_WORDS && (i - HDR_WORDS) < MAX_CMDS) begin
                model_cmd(pk[i], r);
                res.push_back(r);
            end
        end
        if (res.size() > 0) begin
            exp_q.push_back(dip);
            exp_q.push_back(sip);
            exp_q.push_back({ports[15:0], ports[31:16]});
            exp_q.push_back({16'(4 * res.size()), 16'h0});
            foreach (res[i]) exp_q.push_back(res[i]);
        end
        @(negedge clk);
        if (pk.size() > HDR_WORDS) check("reg_out_after_cmd", reg_out, model_regout());
        UPL_input_en   = 1'b0;
        UPL_input_data = 32'h0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !UPL_output_en && !UPL_output_req) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL reply_timeout: got %0d words outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ack"},   {31'h0, UPL_input_ack},  32'h0);
        check({tag, "_out_req"},  {31'h0, UPL_output_req}, 32'h0);
        check({tag, "_out_en"},   {31'h0, UPL_output_en},  32'h0);
        check({tag, "_out_data"}, UPL_output_data,         32'h0);
        check({tag, "_reg_out"},  reg_out,                 32'h0);
    endtask

    // Core side of the reply handshake: acknowledge a request after ack_delay cycles
    always begin
        @(negedge clk);
        if (UPL_output_req && !reset) begin
            repeat (ack_delay) @(negedge clk);
            UPL_output_ack = 1'b1;
            @(negedge clk);
            UPL_output_ack = 1'b0;
        end
    end

    // Scoreboard monitor: every reply word is compared against the oldest prediction
    always @(negedge clk) begin
        if (!reset && UPL_output_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_reply_word: got %08h expected no word", UPL_output_data);
            end else begin
                check("reply_word", UPL_output_data, exp_q.pop_front());
            end
        end
        if (!reset && UPL_input_ack)
            check("in_ack_while_replying", {30'h0, UPL_output_req, UPL_output_en}, 32'h0);
    end

    initial begin
        bit seen;
        for (int i = 0; i < N_REG; i++) m_regs[i] = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        cmd_q = {32'h4100_00A5};
        send_packet(32'hC0A8_0001, 32'hC0A8_0002, {16'd1234, 16'd5678});
        wait_idle();

        cmd_q = {32'h4200_0033, 32'h8200_0000};
        send_packet(32'h0A00_0001, 32'h0A00_0002, {16'h1111, 16'h2222});
        wait_idle();

        cmd_q = {32'h4500_0011, 32'hC000_0000, 32'h8100_0000};
        send_packet(32'h0A00_0003, 32'h0A00_0004, {16'h3333, 16'h4444});
        wait_idle();

        for (int i = 0; i < 20; i++) cmd_q.push_back({2'b10, 6'(i % N_REG), 24'h0});
        send_packet(32'h0A00_0005, 32'h0A00_0006, {16'h5555, 16'h6666});
        wait_idle();

        send_packet(32'h0A00_0007, 32'h0A00_0008, {16'h7777, 16'h8888});
        wait_idle();

        ack_delay = 10;
        cmd_q = {32'h4000_0012, 32'h4300_0034, 32'h8000_0000};
        send_packet(32'h0B00_0001, 32'h0B00_0002, {16'h0101, 16'h0202});
        cmd_q = {32'h8300_0000, 32'h4100_0056};
        send_packet(32'h0B00_0003, 32'h0B00_0004, {16'h0303, 16'h0404});
        wait_idle();
        ack_delay = 0;

        for (int i = 0; i < 8; i++) cmd_q.push_back({2'b01, 6'(i % N_REG), 24'(8'h90 + i)});
        send_packet(32'h0C00_0001, 32'h0C00_0002, {16'h0505, 16'h0606});
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (UPL_output_en) seen = 1'b1;
        end
        if (!seen) check("tx_start_before_reset", {31'h0, UPL_output_en}, 32'h1);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("mid_tx_reset");
        exp_q.delete();
        for (int i = 0; i < N_REG; i++) m_regs[i] = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("after_reset");

        cmd_q = {32'h4300_0077, 32'h8300_0000};
        send_packet(32'h0D00_0001, 32'h0D00_0002, {16'h0707, 16'h0808});
        wait_idle();

        for (int p = 0; p < 25; p++) begin
            int n;
            ack_delay = $urandom_range(0, 4);
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++)
                cmd_q.push_back({2'($urandom_range(0, 3)), 6'($urandom_range(0, 6)), 24'($urandom)});
            send_packet($urandom, $urandom, $urandom);
            wait_idle();
        end

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
